// File: rtl/multiplier.sv
// Bus-slave 32x32 unsigned multiplier using a radix-2 shift-add datapath with a fixed
// 32-cycle execution time. Read data reflects the post-edge register state.
module multiplier (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        m_interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_opa, w_opa_nxt;
  logic [31:0] r_opb, w_opb_nxt;
  logic        r_int_en, w_int_en_nxt;
  logic        r_done, w_done_nxt;
  logic [63:0] r_a, w_a_nxt;
  logic [31:0] r_b, w_b_nxt;
  logic [63:0] r_prod, w_prod_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_dout, w_rdata;

  logic w_wr, w_rd, w_addr_ok, w_start, w_clear, w_busy_nxt;

  assign w_wr      = S_sel & S_wr;
  assign w_rd      = S_sel & ~S_wr;
  assign w_addr_ok = (S_address[7:3] == 5'd0);
  assign w_start   = w_wr & w_addr_ok & (S_address[2:0] == 3'd3) & S_din[0];
  assign w_clear   = w_wr & w_addr_ok & (S_address[2:0] == 3'd4) & S_din[0];

  // Next-state and datapath; clear overrides every other event.
  always_comb begin
    w_state_nxt  = r_state;
    w_opa_nxt    = r_opa;
    w_opb_nxt    = r_opb;
    w_int_en_nxt = r_int_en;
    w_done_nxt   = r_done;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_prod_nxt   = r_prod;
    w_cnt_nxt    = r_cnt;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
      w_opa_nxt   = 32'd0;
      w_opb_nxt   = 32'd0;
      w_a_nxt     = 64'd0;
      w_b_nxt     = 32'd0;
      w_prod_nxt  = 64'd0;
      w_cnt_nxt   = 5'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_wr && w_addr_ok) begin
            case (S_address[2:0])
              3'd0:    w_opa_nxt    = S_din;
              3'd1:    w_opb_nxt    = S_din;
              3'd2:    w_int_en_nxt = S_din[0];
              default: w_opa_nxt    = r_opa;
            endcase
          end else begin
            w_opa_nxt = r_opa;
          end
          if (w_start) begin
            w_a_nxt     = {32'd0, r_opa};
            w_b_nxt     = r_opb;
            w_prod_nxt  = 64'd0;
            w_cnt_nxt   = 5'd0;
            w_done_nxt  = 1'b0;
            w_state_nxt = ST_EXEC;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_EXEC: begin
          if (r_b[0]) begin
            w_prod_nxt = r_prod + r_a;
          end else begin
            w_prod_nxt = r_prod;
          end
          w_a_nxt   = {r_a[62:0], 1'b0};
          w_b_nxt   = {1'b0, r_b[31:1]};
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_EXEC;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_busy_nxt = (w_state_nxt == ST_EXEC);

  // Read mux over post-edge values so a status read on the final edge already sees done.
  always_comb begin
    w_rdata = 32'd0;
    if (w_rd && w_addr_ok) begin
      case (S_address[2:0])
        3'd0:    w_rdata = w_opa_nxt;
        3'd1:    w_rdata = w_opb_nxt;
        3'd2:    w_rdata = {31'd0, w_int_en_nxt};
        3'd5:    w_rdata = {30'd0, w_busy_nxt, w_done_nxt};
        3'd6:    w_rdata = w_prod_nxt[31:0];
        3'd7:    w_rdata = w_prod_nxt[63:32];
        default: w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_opa    <= 32'd0;
      r_opb    <= 32'd0;
      r_int_en <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= 64'd0;
      r_b      <= 32'd0;
      r_prod   <= 64'd0;
      r_cnt    <= 5'd0;
      r_dout   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_opa    <= w_opa_nxt;
      r_opb    <= w_opb_nxt;
      r_int_en <= w_int_en_nxt;
      r_done   <= w_done_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_prod   <= w_prod_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dout   <= w_rdata;
    end
  end

  assign S_dout      = r_dout;
  assign m_interrupt = r_done & r_int_en;

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the bus-slave multiplier; expected values are hand-computed.
module tb_multiplier;

  logic        clk;
  logic        reset_n;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S_dout;
  logic        m_interrupt;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] rd;

  multiplier dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .S_sel       (S_sel),
    .S_wr        (S_wr),
    .S_address   (S_address),
    .S_din       (S_din),
    .S_dout      (S_dout),
    .m_interrupt (m_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    S_sel = 1'b1; S_wr = 1'b1; S_address = addr; S_din = data;
    @(posedge clk);
    #1;
    S_sel = 1'b0; S_wr = 1'b0; S_address = 8'd0; S_din = 32'd0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    S_sel = 1'b1; S_wr = 1'b0; S_address = addr;
    @(posedge clk);
    #1;
    S_sel = 1'b0; S_address = 8'd0;
    data = S_dout;
  endtask

  // Starts an operation and returns just after edge T32.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    bus_write(8'h00, a);
    bus_write(8'h01, b);
    bus_write(8'h03, 32'd1);
    wait_edges(32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_address = 8'd0; S_din = 32'd0;
    wait_edges(3);
    reset_n = 1'b1;
    wait_edges(1);

    check_val("rst_irq", 64'(m_interrupt), 64'd0);
    check_val("rst_dout", 64'(S_dout), 64'd0);
    bus_read(8'h05, rd); check_val("rst_status", 64'(rd), 64'd0);
    bus_read(8'h00, rd); check_val("rst_opa", 64'(rd), 64'd0);
    bus_read(8'h20, rd); check_val("bad_addr", 64'(rd), 64'd0);

    // Basic product and interrupt timing
    bus_write(8'h00, 32'd5);
    bus_write(8'h01, 32'd4);
    bus_write(8'h02, 32'd1);
    bus_write(8'h03, 32'd1);
    wait_edges(31);
    check_val("irq_T31", 64'(m_interrupt), 64'd0);
    wait_edges(1);
    check_val("irq_T32", 64'(m_interrupt), 64'd1);
    bus_read(8'h06, rd); check_val("5x4_lo", 64'(rd), 64'd20);
    bus_read(8'h07, rd); check_val("5x4_hi", 64'(rd), 64'd0);
    bus_read(8'h02, rd); check_val("int_en_rd", 64'(rd), 64'd1);
    bus_write(8'h04, 32'd1);
    check_val("irq_clear", 64'(m_interrupt), 64'd0);

    // Chained factorial steps
    run_op(32'd20, 32'd3);
    bus_read(8'h06, rd); check_val("20x3_lo", 64'(rd), 64'd60);
    bus_read(8'h07, rd); check_val("20x3_hi", 64'(rd), 64'd0);
    bus_write(8'h04, 32'd1);
    run_op(32'd60, 32'd2);
    bus_read(8'h06, rd); check_val("60x2_lo", 64'(rd), 64'd120);
    bus_read(8'h07, rd); check_val("60x2_hi", 64'(rd), 64'd0);
    bus_write(8'h04, 32'd1);

    // Width corner
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus_read(8'h07, rd); check_val("max_hi", 64'(rd), 64'hFFFF_FFFE);
    bus_read(8'h06, rd); check_val("max_lo", 64'(rd), 64'h0000_0001);
    bus_write(8'h04, 32'd1);

    // Zero operand; status read issued on edge T32 must already show done
    bus_write(8'h00, 32'd0);
    bus_write(8'h01, 32'h1234);
    bus_write(8'h03, 32'd1);
    wait_edges(31);
    bus_read(8'h05, rd); check_val("zero_status_T32", 64'(rd), 64'h1);
    bus_read(8'h06, rd); check_val("zero_lo", 64'(rd), 64'd0);
    bus_read(8'h07, rd); check_val("zero_hi", 64'(rd), 64'd0);
    bus_write(8'h04, 32'd1);

    // Interrupt masked
    bus_write(8'h02, 32'd0);
    run_op(32'd7, 32'd6);
    check_val("masked_irq", 64'(m_interrupt), 64'd0);
    bus_read(8'h05, rd); check_val("masked_status", 64'(rd), 64'h1);
    bus_read(8'h06, rd); check_val("7x6_lo", 64'(rd), 64'd42);
    bus_write(8'h02, 32'd1);
    check_val("unmask_irq", 64'(m_interrupt), 64'd1);
    bus_write(8'h04, 32'd1);
    bus_read(8'h02, rd); check_val("int_en_kept", 64'(rd), 64'd1);

    // Busy protection: writes at T1/T2, status read at T3
    bus_write(8'h00, 32'd11);
    bus_write(8'h01, 32'd13);
    bus_write(8'h03, 32'd1);
    bus_write(8'h00, 32'd99);
    bus_write(8'h03, 32'd1);
    bus_read(8'h05, rd); check_val("busy_status", 64'(rd), 64'h2);
    wait_edges(28);
    check_val("busy_irq_T31", 64'(m_interrupt), 64'd0);
    wait_edges(1);
    check_val("busy_irq_T32", 64'(m_interrupt), 64'd1);
    bus_read(8'h06, rd); check_val("11x13_lo", 64'(rd), 64'd143);
    bus_read(8'h00, rd); check_val("opa_kept", 64'(rd), 64'd11);
    bus_write(8'h04, 32'd1);

    // Clear at T10 aborts
    bus_write(8'h00, 32'd7);
    bus_write(8'h01, 32'd9);
    bus_write(8'h03, 32'd1);
    wait_edges(9);
    bus_write(8'h04, 32'd1);
    bus_read(8'h05, rd); check_val("abort_status", 64'(rd), 64'd0);
    wait_edges(30);
    check_val("abort_irq", 64'(m_interrupt), 64'd0);
    bus_read(8'h06, rd); check_val("abort_lo", 64'(rd), 64'd0);
    bus_read(8'h07, rd); check_val("abort_hi", 64'(rd), 64'd0);

    // Reset pulse at T15 aborts immediately
    bus_write(8'h00, 32'd5);
    bus_write(8'h01, 32'd5);
    bus_write(8'h03, 32'd1);
    wait_edges(14);
    reset_n = 1'b0;
    #2;
    check_val("rst_mid_irq", 64'(m_interrupt), 64'd0);
    check_val("rst_mid_dout", 64'(S_dout), 64'd0);
    reset_n = 1'b1;
    wait_edges(1);
    bus_read(8'h05, rd); check_val("rst_mid_status", 64'(rd), 64'd0);
    bus_read(8'h02, rd); check_val("rst_mid_int_en", 64'(rd), 64'd0);
    bus_read(8'h00, rd); check_val("rst_mid_opa", 64'(rd), 64'd0);
    bus_write(8'h02, 32'd1);
    run_op(32'd3, 32'd3);
    check_val("3x3_irq", 64'(m_interrupt), 64'd1);
    bus_read(8'h06, rd); check_val("3x3_lo", 64'(rd), 64'd9);
    bus_write(8'h03, 32'd1);
    check_val("restart_irq_drop", 64'(m_interrupt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Bus-slave 32×32 unsigned multiplier serving as the responder that the factorial engine drives over its master port. The factorial master writes operands and a start command through the slave register interface and waits for `m_interrupt`. It then reads the 64-bit product and clears the block. The multiplier is a radix-2 shift-add sequential datapath with a fixed 32-cycle execution time.

## Interface
- No parameters; widths are fixed.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `S_sel`  in  1  slave select; an access occurs on any rising edge with `S_sel`=1.
- `S_wr`  in  1  1 = write, 0 = read; qualified by `S_sel`.
- `S_address`  in  8  register address; only bits [2:0] are decoded when [7:3]=0. Other addresses read 0 and ignore writes.
- `S_din`  in  32  write data.
- `S_dout`  out  32  registered read data.
- `m_interrupt`  out  1  level interrupt; equals `done` AND `int_en`.

## Operation
- Register map (R = read, W = write):
  - 0x00 `opa` R/W: multiplicand.
  - 0x01 `opb` R/W: multiplier.
  - 0x02 `int_en` R/W: bit0 only; upper bits read 0.
  - 0x03 `start` W: writing bit0=1 issues start; reads 0.
  - 0x04 `clear` W: writing bit0=1 issues clear; reads 0.
  - 0x05 `status` R: bit0=`done`, bit1=`busy`.
  - 0x06 `result_lo` R: product[31:0].
  - 0x07 `result_hi` R: product[63:32].
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE or DONE + start write:
  - Latch `opa` into a 64-bit shift register A (zero-extended) and `opb` into a 32-bit shift register B.
  - Zero the product and the counter.
  - Clear `done` and go to EXEC.
- EXEC, each cycle:
  - If B[0]=1, product += A (64-bit add, no overflow possible).
  - A <<= 1, B >>= 1, counter += 1.
  - After the counter reaches 31 (32nd EXEC cycle), go to DONE and set `done`=1.
- DONE: the product is held stable until the next start, clear, or reset.
- Clear write, in any state:
  - Go to IDLE; `done`=0.
  - Product, `opa`, `opb` reset to 0.
  - `int_en` is preserved.
- Writes to `opa`, `opb`, and `int_en` are ignored while busy (EXEC). Start writes during EXEC are ignored.
- Simultaneous events: a start write and the final EXEC cycle cannot coincide because start is ignored in EXEC. Clear beats everything.
- `int_en` may be changed in IDLE or DONE; `m_interrupt` follows combinationally from the registered `done` and `int_en`.

## Timing
- Reset (async, `reset_n`=0) forces all of the following to 0 immediately:
  - `S_dout`, `m_interrupt`, `done`, `busy`, `int_en`, `opa`, `opb`, product, counter.
  - The FSM goes to IDLE.
- Read latency is 1 cycle. The edge where `S_sel`=1 and `S_wr`=0 loads `S_dout` with the addressed register. On every other edge, `S_dout` loads 0.
- Write takes effect on the edge where `S_sel`=1 and `S_wr`=1. Back-to-back writes on consecutive cycles are all accepted.
- The start-write edge is T0:
  - `busy`=1 from T0 through T31.
  - `done` and `m_interrupt` rise after edge T32, which is also when the product becomes valid.
  - A `status` read issued on edge T32 returns `done`=1 on `S_dout` after T32.
- `m_interrupt` remains high until a clear write or the next start write. It drops on that edge.
- A clear during EXEC aborts the operation on the same edge; no interrupt is produced.
- Reset asserted mid-EXEC aborts immediately. After release, the block behaves as freshly reset.

## Test plan
- Basic product and interrupt:
  - Stimulus: write `opa`=5, `opb`=4, `int_en`=1, `start`=1.
  - Required: `m_interrupt` rises exactly 32 cycles after the start edge; `result_lo` reads 20 and `result_hi` reads 0.
  - Then write `clear`=1; required: `m_interrupt` falls on that edge.
- Chained factorial sequence:
  - Stimulus: run 20×3, then 60×2, clearing between operations.
  - Required: reads return 60, then 120. `result_hi`=0 each time.
- Width corner:
  - Stimulus: `opa`=`opb`=0xFFFFFFFF.
  - Required: `result_hi`=0xFFFFFFFE and `result_lo`=0x00000001.
  - Zero case: `opa`=0, `opb`=0x1234 → product 0, `done` still after 32 cycles.
- Interrupt masked:
  - Stimulus: `int_en`=0, 7×6.
  - Required: `m_interrupt` stays 0, `status` reads 0x1, `result_lo`=42.
  - Then write `int_en`=1; required: `m_interrupt` rises on the next cycle.
- Busy protection:
  - Stimulus: during EXEC, write `opa`=99 and `start`=1.
  - Required: the operation completes unchanged at T32 with the original product, and `opa` still reads the original value.
- Abort paths:
  - Stimulus: clear at T10 of EXEC.
  - Required: IDLE, `status`=0, no interrupt, both result registers read 0.
  - Stimulus: `reset_n` pulse at T15.
  - Required: all outputs 0 immediately, and a subsequent 3×3 returns 9.
